// File: rtl/reg_serializer.sv
// Parallel-to-serial shifter, LSB first, with ready/valid/done handshake and registered outputs.
// Define REG_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module reg_serializer #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] data,
  input  logic             load,
  output logic             ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

  localparam int CW = $clog2(width) + 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

`ifdef REG_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [width-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             done_q, done_d;
`ifdef REG_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    done_d      = 1'b0;
`ifdef REG_SERIALIZER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d     = 1'b1;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        if (load && ready_q) begin
          // Output flops are loaded with bit 0 now so it appears one cycle after acceptance.
          shift_d     = data;
          cnt_d       = '0;
          state_d     = SHIFT;
          ready_d     = 1'b0;
          ser_out_d   = data[0];
          ser_valid_d = 1'b1;
`ifdef REG_SERIALIZER_PARITY_EN
          par_d       = 1'b0;
`endif
        end
      end
      SHIFT: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CW'(1);
`ifdef REG_SERIALIZER_PARITY_EN
        par_d   = par_q ^ shift_q[0];
`endif
        if (cnt_q == LAST) begin
`ifdef REG_SERIALIZER_PARITY_EN
          state_d     = PARITY;
          ser_out_d   = par_q ^ shift_q[0];
          ser_valid_d = 1'b1;
`else
          state_d     = DONE;
          ser_out_d   = 1'b0;
          ser_valid_d = 1'b0;
          done_d      = 1'b1;
`endif
        end else begin
          ser_out_d   = shift_q[1];
          ser_valid_d = 1'b1;
        end
      end
`ifdef REG_SERIALIZER_PARITY_EN
      PARITY: begin
        state_d     = DONE;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        done_d      = 1'b1;
      end
`endif
      DONE: begin
        state_d     = IDLE;
        ready_d     = 1'b1;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        ready_d     = 1'b1;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef REG_SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
`ifdef REG_SERIALIZER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign ready     = ready_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_serializer.sv
// Directed bench for reg_serializer (width=8): frame table plus busy-load, mid-word reset and back-to-back sequences.
module tb_reg_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       load;
  logic       ready;
  logic       ser_out;
  logic       ser_valid;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  reg_serializer #(.width(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .load     (load),
    .ready    (ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       parity;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Called at a negedge with the block idle; returns at the negedge of the following IDLE cycle.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic hold, input logic [7:0] nxt);
    check("ready_before_load", ready, 1'b1);
    data = d;
    load = 1'b1;
    @(negedge clk);
    load = hold;
    data = nxt;
    for (int i = 0; i < 8; i++) begin
      check("shift_valid", ser_valid, 1'b1);
      check("shift_bit", ser_out, d[i]);
      check("shift_ready", ready, 1'b0);
      check("shift_done", done, 1'b0);
      @(negedge clk);
    end
`ifdef REG_SERIALIZER_PARITY_EN
    check("parity_valid", ser_valid, 1'b1);
    check("parity_bit", ser_out, p);
    check("parity_done", done, 1'b0);
    @(negedge clk);
`else
    if (p !== 1'bx) begin end
`endif
    check("done_pulse", done, 1'b1);
    check("done_valid", ser_valid, 1'b0);
    check("done_ready", ready, 1'b0);
    @(negedge clk);
    check("idle_ready", ready, 1'b1);
    check("idle_done", done, 1'b0);
    check("idle_valid", ser_valid, 1'b0);
    check("idle_out", ser_out, 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0};
    vecs[2] = '{8'h01, 1'b1};
    vecs[3] = '{8'h80, 1'b1};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h00, 1'b0};
    vecs[6] = '{8'h07, 1'b1};
    vecs[7] = '{8'h03, 1'b0};

    // Reset held with load active and changing data
    reset = 1'b0;
    load  = 1'b1;
    data  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      data = 8'($urandom);
      @(negedge clk);
      check("rst_ready", ready, 1'b1);
      check("rst_valid", ser_valid, 1'b0);
      check("rst_out", ser_out, 1'b0);
      check("rst_done", done, 1'b0);
    end
    load  = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) send_frame(vecs[v].data, vecs[v].parity, 1'b0, ~vecs[v].data);

    // Load pulsed while busy must be ignored
    @(negedge clk);
    check("busy_ready_before", ready, 1'b1);
    data = 8'h00;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("busy_valid", ser_valid, 1'b1);
      check("busy_bit", ser_out, 1'b0);
      if (i == 3) begin
        data = 8'hFF;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
`ifdef REG_SERIALIZER_PARITY_EN
    check("busy_parity", ser_out, 1'b0);
    @(negedge clk);
`endif
    check("busy_done", done, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      check("busy_no_extra_frame", ser_valid, 1'b0);
      check("busy_no_extra_done", done, 1'b0);
      @(negedge clk);
    end

    // Mid-word reset aborts, then first edge after release accepts a new load
    data = 8'hFF;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_bit", ser_out, 1'b1);
      @(negedge clk);
    end
    check("abort_bit4_valid", ser_valid, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("abort_valid_async", ser_valid, 1'b0);
    check("abort_ready_async", ready, 1'b1);
    check("abort_out_async", ser_out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
      check("abort_hold_valid", ser_valid, 1'b0);
    end
    reset = 1'b1;
    send_frame(8'h81, 1'b0, 1'b0, 8'h00);

    // Back-to-back with load held high
    @(negedge clk);
    send_frame(8'h01, 1'b1, 1'b1, 8'h80);
    send_frame(8'h80, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("b2b_quiet_valid", ser_valid, 1'b0);
    check("b2b_quiet_done", done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_serializer.md
REG_SERIALIZER -- requirements
Module: reg_serializer

Interface
REQ-001 Parameter: width, default 8, data word width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock for all sequential logic.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-004 Port: data  input  width  parallel word to serialize, sampled only when load is accepted.
REQ-005 Port: load  input  1  request to capture data and begin transmission.
REQ-006 Port: ready  output  1  high when the block can accept load.
REQ-007 Port: ser_out  output  1  serial data bit, LSB first.
REQ-008 Port: ser_valid  output  1  high on every cycle ser_out carries a valid bit.
REQ-009 Port: done  output  1  single-cycle pulse after the last bit of a word.

Function
REQ-010 FSM states SHALL be IDLE, SHIFT, PARITY (present only per REQ-024) and DONE.
REQ-011 In IDLE: ready=1, ser_valid=0, ser_out=0, done=0.
REQ-012 Load is accepted on a rising edge with load=1 and ready=1; data is captured into an internal shift register, the bit counter is cleared, and the FSM enters SHIFT.
REQ-013 Load while ready=0 SHALL be ignored; no queuing, and captured data is not disturbed.
REQ-014 In SHIFT: ser_valid=1, ser_out=shift register bit 0; each cycle shifts right by one and increments the bit counter.
REQ-015 First bit appears on the cycle immediately after load acceptance, so latency from load to first bit is 1 cycle.
REQ-016 After exactly width SHIFT cycles (counter = width-1 on the last one), the FSM goes to PARITY if enabled, else DONE.
REQ-017 Counter width SHALL be $clog2(width)+1 bits; the counter never wraps during a word.
REQ-018 In DONE: done=1 for exactly one cycle, ser_valid=0, ready=0; next state IDLE.
REQ-019 ready SHALL be 0 in SHIFT, PARITY and DONE, so back-to-back words have a minimum gap of one DONE cycle plus one IDLE cycle.
REQ-020 Changes on data after load acceptance SHALL NOT affect the transmitted word.
REQ-021 All outputs SHALL be registered (driven from flops or decoded from the state register only); no combinational path from load or data to outputs.

Reset
REQ-022 While reset=0: FSM=IDLE, shift register=0, counter=0, parity accumulator=0, ready=1, ser_out=0, ser_valid=0, done=0, independent of clk.
REQ-023 Reset asserted mid-word SHALL abort the transfer with no done pulse; after release the block is in IDLE and accepts load on the first rising edge.

Configuration
REQ-024 Macro REG_SERIALIZER_PARITY_EN: when defined, the PARITY state exists; for one cycle ser_valid=1 and ser_out=even-parity bit (XOR of all width data bits) before DONE, so a frame is width+1 bits.
REQ-025 Without REG_SERIALIZER_PARITY_EN: no PARITY state or parity logic; SHIFT goes directly to DONE, and a frame is width bits.

Verification
REQ-026 Reset: hold reset=0 with load=1 and random data -> ready=1, ser_valid=0, ser_out=0, done=0 throughout.
REQ-027 Basic frame (width=8, no macro): load data=8'hA5 -> ser_out sequence 1,0,1,0,0,1,0,1 over 8 cycles with ser_valid=1, then done=1 for one cycle, then ready=1.
REQ-028 Parity (macro defined): data=8'h07 -> 8 data bits 1,1,1,0,0,0,0,0 then parity bit 1, then done; data=8'h03 -> parity bit 0.
REQ-029 Busy load: pulse load with data=8'hFF during bit 3 of frame 8'h00 -> all ser_out bits stay 0, no extra frame is produced.
REQ-030 Mid-word reset: assert reset during bit 4 of 8'hFF -> ser_valid drops at once, no done pulse; new load 8'h81 after release transmits correctly.
REQ-031 Back-to-back: hold load=1 continuously with data 8'h01 then 8'h80 -> two complete frames separated by the DONE and IDLE cycles, with two done pulses.
